// File: rtl/uart_rx_status_if.sv
// Bus bundle between the UART RX engine/FIFO/host registers and the receive status stage.
interface uart_rx_status_if;
    logic        enable;
    logic [7:0]  LCR;
    logic [1:0]  FCR_trig;
    logic        fifo_clear;
    logic [10:0] rx_fifo_out;
    logic [4:0]  rx_fifo_count;
    logic        rx_fifo_empty;
    logic        rx_fifo_full;
    logic        push_rx_fifo;
    logic        rx_overrun;
    logic        parity_error;
    logic        framing_error;
    logic        break_error;
    logic        rbr_rd;
    logic        lsr_rd;
    logic        pop_rx_fifo;
    logic [7:0]  rbr;
    logic [7:0]  lsr;
    logic        rx_data_irq;
    logic        rx_line_irq;
    logic        rx_timeout_irq;

    modport master (
        output enable, LCR, FCR_trig, fifo_clear, rx_fifo_out, rx_fifo_count,
               rx_fifo_empty, rx_fifo_full, push_rx_fifo, rx_overrun,
               parity_error, framing_error, break_error, rbr_rd, lsr_rd,
        input  pop_rx_fifo, rbr, lsr, rx_data_irq, rx_line_irq, rx_timeout_irq
    );

    modport slave (
        input  enable, LCR, FCR_trig, fifo_clear, rx_fifo_out, rx_fifo_count,
               rx_fifo_empty, rx_fifo_full, push_rx_fifo, rx_overrun,
               parity_error, framing_error, break_error, rbr_rd, lsr_rd,
        output pop_rx_fifo, rbr, lsr, rx_data_irq, rx_line_irq, rx_timeout_irq
    );
endinterface

// File: rtl/uart_rx_status.sv
// UART receive status stage: RBR pop/word masking, receive LSR bits and RX interrupt requests.
// Define UART_RX_TIMEOUT_EN to build the character-timeout counter; otherwise rx_timeout_irq is 0.
module uart_rx_status (
    input  logic            PCLK,
    input  logic            PRESET,
    uart_rx_status_if.slave bus
);
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned TO_W       = 10;

    logic             pop_c;
    logic [7:0]       word_mask_c;
    logic             head_eval_c;
    logic             err_inc_c;
    logic             err_dec_c;
    logic [CNT_W-1:0] trig_c;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] err_cnt_nxt_c;
    logic             oe;
    logic             pe;
    logic             fe;
    logic             bi;
    logic             head_seen;
    logic             data_irq;
    logic             unused_lcr;

    assign pop_c       = bus.rbr_rd & ~bus.rx_fifo_empty;
    assign word_mask_c = 8'hFF >> (2'd3 - bus.LCR[1:0]);
    assign head_eval_c = ~bus.rx_fifo_empty & ~head_seen;
    assign err_inc_c   = bus.push_rx_fifo & ~bus.rx_fifo_full &
                         (bus.parity_error | bus.framing_error | bus.break_error);
    assign err_dec_c   = pop_c & (|bus.rx_fifo_out[10:8]);
    assign unused_lcr  = ^bus.LCR[7:4];

    // Trigger level decode for the received-data interrupt
    always_comb begin
        trig_c = CNT_W'(1);
        case (bus.FCR_trig)
            2'b00:   trig_c = CNT_W'(1);
            2'b01:   trig_c = CNT_W'(4);
            2'b10:   trig_c = CNT_W'(8);
            default: trig_c = CNT_W'(14);
        endcase
    end

    // Count of FIFO entries carrying an error; an inc/dec pair cancels
    always_comb begin
        err_cnt_nxt_c = err_cnt;
        if (bus.fifo_clear) begin
            err_cnt_nxt_c = '0;
        end else if (err_inc_c && !err_dec_c && (err_cnt != CNT_W'(FIFO_DEPTH))) begin
            err_cnt_nxt_c = err_cnt + CNT_W'(1);
        end else if (err_dec_c && !err_inc_c && (err_cnt != '0)) begin
            err_cnt_nxt_c = err_cnt - CNT_W'(1);
        end
    end

    // Sticky LSR bits: a set in the same cycle as an LSR read wins
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            oe        <= 1'b0;
            pe        <= 1'b0;
            fe        <= 1'b0;
            bi        <= 1'b0;
            head_seen <= 1'b0;
            err_cnt   <= '0;
            data_irq  <= 1'b0;
        end else begin
            oe        <= (oe & ~bus.lsr_rd) | (bus.push_rx_fifo & bus.rx_overrun);
            pe        <= (pe & ~bus.lsr_rd) | (head_eval_c & bus.rx_fifo_out[9]);
            fe        <= (fe & ~bus.lsr_rd) | (head_eval_c & bus.rx_fifo_out[8]);
            bi        <= (bi & ~bus.lsr_rd) | (head_eval_c & bus.rx_fifo_out[10]);
            head_seen <= (pop_c | bus.fifo_clear) ? 1'b0 : (head_seen | head_eval_c);
            err_cnt   <= err_cnt_nxt_c;
            data_irq  <= (bus.rx_fifo_count >= trig_c);
        end
    end

    assign bus.pop_rx_fifo = pop_c;
    assign bus.rbr         = bus.rx_fifo_empty ? 8'h00 : (bus.rx_fifo_out[7:0] & word_mask_c);
    assign bus.lsr         = {(err_cnt != '0), 2'b00, bi, fe, pe, oe, ~bus.rx_fifo_empty};
    assign bus.rx_data_irq = data_irq;
    assign bus.rx_line_irq = oe | pe | fe | bi;

`ifdef UART_RX_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_irq;
    logic            to_rst_c;
    logic [3:0]      frame_bits_c;
    logic [TO_W-1:0] to_limit_c;

    // Four character times = 64 ticks per frame bit
    assign frame_bits_c = 4'd7 + 4'(bus.LCR[1:0]) + 4'(bus.LCR[3]) + 4'(bus.LCR[2]);
    assign to_limit_c   = {frame_bits_c, 6'd0};
    assign to_rst_c     = bus.rx_fifo_empty | bus.push_rx_fifo | pop_c | bus.fifo_clear;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            to_cnt <= '0;
            to_irq <= 1'b0;
        end else begin
            if (to_rst_c) begin
                to_cnt <= '0;
            end else if (bus.enable && (to_cnt != '1)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (pop_c || bus.fifo_clear || bus.rx_fifo_empty) begin
                to_irq <= 1'b0;
            end else if (to_cnt >= to_limit_c) begin
                to_irq <= 1'b1;
            end
        end
    end

    assign bus.rx_timeout_irq = to_irq;
`else
    logic unused_enable;
    assign unused_enable      = bus.enable;
    assign bus.rx_timeout_irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_status.sv
// Self-checking bench for uart_rx_status: queue-based FIFO plus a reference model of the receive status rules.
module tb_uart_rx_status;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_status_if bus ();
    uart_rx_status dut (.PCLK(clk), .PRESET(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [10:0] q [$];
    logic m_oe, m_pe, m_fe, m_bi, m_head, m_dirq, m_tirq;
    int   m_idle;
    logic [7:0] pdata;
    bit   check_en = 1'b0;
    int   waited;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int trig_level(input logic [1:0] t);
        case (t)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 14;
        endcase
    endfunction

    function automatic int frame_bits(input logic [7:0] lcr);
        return 1 + 5 + int'(lcr[1:0]) + int'(lcr[3]) + 1 + int'(lcr[2]);
    endfunction

    function automatic int err_entries();
        int n = 0;
        foreach (q[i]) if (q[i][10:8] != 3'b000) n++;
        return n;
    endfunction

    task automatic drive_fifo();
        bus.rx_fifo_out   = (q.size() != 0) ? q[0] : 11'($urandom);
        bus.rx_fifo_count = 5'(q.size());
        bus.rx_fifo_empty = (q.size() == 0);
        bus.rx_fifo_full  = (q.size() == 16);
    endtask

    task automatic check_all();
        logic [7:0] mask;
        logic [7:0] rbr_e;
        logic [7:0] lsr_e;
        logic       pop_e;
        logic       ferr;
        logic       dr;
        pop_e = bus.rbr_rd && (q.size() != 0);
        mask  = 8'((1 << (5 + int'(bus.LCR[1:0]))) - 1);
        rbr_e = (q.size() == 0) ? 8'h00 : (q[0][7:0] & mask);
        ferr  = (err_entries() != 0);
        dr    = (q.size() != 0);
        lsr_e = {ferr, 2'b00, m_bi, m_fe, m_pe, m_oe, dr};
        chk("pop", 16'(bus.pop_rx_fifo), 16'(pop_e));
        chk("rbr", 16'(bus.rbr), 16'(rbr_e));
        chk("lsr", 16'(bus.lsr), 16'(lsr_e));
        chk("line_irq", 16'(bus.rx_line_irq), 16'(m_oe | m_pe | m_fe | m_bi));
        chk("data_irq", 16'(bus.rx_data_irq), 16'(m_dirq));
        chk("timeout_irq", 16'(bus.rx_timeout_irq), 16'(m_tirq));
    endtask

    // One clock: check current outputs, advance the model, clear one-shot strobes
    task automatic cycle();
        logic ne, pop_e, full_b, hd;
        logic n_oe, n_pe, n_fe, n_bi, n_head, n_dirq, n_tirq;
        int   n_idle;
        #1;
        if (check_en) check_all();
        ne     = (q.size() != 0);
        full_b = (q.size() == 16);
        pop_e  = bus.rbr_rd && ne;
        if (rst) begin
            {n_oe, n_pe, n_fe, n_bi, n_head, n_dirq, n_tirq} = '0;
            n_idle = 0;
            q.delete();
        end else begin
            hd     = ne && !m_head;
            n_oe   = (m_oe && !bus.lsr_rd) || (bus.push_rx_fifo && bus.rx_overrun);
            n_pe   = (m_pe && !bus.lsr_rd) || (hd && q[0][9]);
            n_fe   = (m_fe && !bus.lsr_rd) || (hd && q[0][8]);
            n_bi   = (m_bi && !bus.lsr_rd) || (hd && q[0][10]);
            n_head = (pop_e || bus.fifo_clear) ? 1'b0 : (ne ? 1'b1 : m_head);
            n_dirq = (q.size() >= trig_level(bus.FCR_trig));
`ifdef UART_RX_TIMEOUT_EN
            if (!ne || bus.push_rx_fifo || pop_e || bus.fifo_clear) n_idle = 0;
            else if (bus.enable && m_idle < 1023) n_idle = m_idle + 1;
            else n_idle = m_idle;
            if (pop_e || bus.fifo_clear || !ne) n_tirq = 1'b0;
            else if (m_idle >= 64 * frame_bits(bus.LCR)) n_tirq = 1'b1;
            else n_tirq = m_tirq;
`else
            n_idle = 0;
            n_tirq = 1'b0;
`endif
            if (bus.fifo_clear) begin
                q.delete();
            end else begin
                if (pop_e) void'(q.pop_front());
                if (bus.push_rx_fifo && !full_b)
                    q.push_back({bus.break_error, bus.parity_error, bus.framing_error, pdata});
            end
        end
        @(posedge clk);
        {m_oe, m_pe, m_fe, m_bi, m_head, m_dirq, m_tirq} = {n_oe, n_pe, n_fe, n_bi, n_head, n_dirq, n_tirq};
        m_idle = n_idle;
        #1;
        drive_fifo();
        bus.push_rx_fifo  = 1'b0;
        bus.rx_overrun    = 1'b0;
        bus.parity_error  = 1'b0;
        bus.framing_error = 1'b0;
        bus.break_error   = 1'b0;
        bus.rbr_rd        = 1'b0;
        bus.lsr_rd        = 1'b0;
        bus.fifo_clear    = 1'b0;
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic f, input logic b, input logic ov);
        pdata             = d;
        bus.push_rx_fifo  = 1'b1;
        bus.parity_error  = p;
        bus.framing_error = f;
        bus.break_error   = b;
        bus.rx_overrun    = ov;
        cycle();
    endtask

    task automatic pop();
        bus.rbr_rd = 1'b1;
        cycle();
    endtask

    task automatic lsr_read();
        bus.lsr_rd = 1'b1;
        cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) pop();
    endtask

    initial begin
        bus.enable = 1'b0; bus.LCR = 8'h03; bus.FCR_trig = 2'b00; bus.fifo_clear = 1'b0;
        bus.push_rx_fifo = 1'b0; bus.rx_overrun = 1'b0; bus.parity_error = 1'b0;
        bus.framing_error = 1'b0; bus.break_error = 1'b0; bus.rbr_rd = 1'b0; bus.lsr_rd = 1'b0;
        pdata = 8'h00;
        {m_oe, m_pe, m_fe, m_bi, m_head, m_dirq, m_tirq} = '0;
        m_idle = 0;
        drive_fifo();
        rst = 1'b1;
        cycle();
        check_en = 1'b1;
        cycle();
        rst = 1'b0;
        chk("reset_lsr", 16'(bus.lsr), 16'h00);
        chk("reset_irqs", 16'({bus.rx_data_irq, bus.rx_line_irq, bus.rx_timeout_irq}), 16'h0);

        // Trigger level 4
        bus.FCR_trig = 2'b01;
        push(8'h11, 0, 0, 0, 0); push(8'h22, 0, 0, 0, 0); push(8'h33, 0, 0, 0, 0);
        cycle();
        chk("trig_below", 16'(bus.rx_data_irq), 16'h0);
        push(8'h44, 0, 0, 0, 0);
        cycle();
        chk("trig_reached", 16'(bus.rx_data_irq), 16'h1);
        pop();
        cycle();
        chk("trig_after_pop", 16'(bus.rx_data_irq), 16'h0);
        drain();

        // Word length masking
        bus.LCR = 8'h00;
        push(8'hFF, 0, 0, 0, 0);
        chk("rbr_5bit", 16'(bus.rbr), 16'h1F);
        bus.LCR = 8'h03;
        #1;
        chk("rbr_8bit", 16'(bus.rbr), 16'hFF);
        drain();

        // Sticky errors and FIFO-error tracking
        push(8'hA1, 0, 1, 0, 0); push(8'hB2, 0, 0, 0, 0); push(8'hC3, 1, 0, 0, 0);
        cycle();
        chk("fe_set", 16'(bus.lsr[3]), 16'h1);
        chk("pe_not_yet", 16'(bus.lsr[2]), 16'h0);
        chk("fifo_err_set", 16'(bus.lsr[7]), 16'h1);
        lsr_read();
        chk("fe_cleared", 16'(bus.lsr[3]), 16'h0);
        pop();
        chk("fifo_err_after_a", 16'(bus.lsr[7]), 16'h1);
        pop();
        cycle();
        chk("pe_from_head_c", 16'(bus.lsr[2]), 16'h1);
        pop();
        chk("fifo_err_clear", 16'(bus.lsr[7]), 16'h0);
        lsr_read();

        // Character timeout, 10-bit frame = 640 ticks
        bus.LCR = 8'h03;
        push(8'h5A, 0, 0, 0, 0);
        bus.enable = 1'b1;
        waited = 0;
        while (!bus.rx_timeout_irq && waited < 700) begin
            cycle();
            waited++;
        end
`ifdef UART_RX_TIMEOUT_EN
        chk("timeout_rise", 16'(bus.rx_timeout_irq), 16'h1);
        chk("timeout_ticks", 16'(waited), 16'd641);
`else
        chk("timeout_off", 16'(bus.rx_timeout_irq), 16'h0);
`endif
        pop();
        chk("timeout_cleared", 16'(bus.rx_timeout_irq), 16'h0);
        bus.enable = 1'b0;

        // Overrun on a full FIFO
        for (int i = 0; i < 16; i++) push(8'(i), 0, 0, 0, 0);
        push(8'hEE, 0, 0, 0, 1);
        chk("oe_set", 16'(bus.lsr[1]), 16'h1);
        chk("oe_line_irq", 16'(bus.rx_line_irq), 16'h1);
        chk("oe_no_fifo_err", 16'(bus.lsr[7]), 16'h0);
        bus.lsr_rd = 1'b1;
        push(8'hEF, 0, 0, 0, 1);
        chk("oe_set_wins", 16'(bus.lsr[1]), 16'h1);
        lsr_read();
        chk("oe_cleared", 16'(bus.lsr[1]), 16'h0);

        // FIFO clear with three errored entries
        bus.fifo_clear = 1'b1;
        cycle();
        push(8'h01, 1, 0, 0, 0); push(8'h02, 0, 1, 0, 0); push(8'h03, 0, 0, 1, 0); push(8'h04, 0, 0, 0, 0);
        bus.enable = 1'b1;
        cycle();
        chk("clr_pre_fifo_err", 16'(bus.lsr[7]), 16'h1);
        bus.fifo_clear = 1'b1;
        cycle();
        chk("clr_fifo_err", 16'(bus.lsr[7]), 16'h0);
        chk("clr_dr", 16'(bus.lsr[0]), 16'h0);
        lsr_read();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.enable = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) bus.LCR = 8'($urandom);
            if ($urandom_range(0, 99) < 3) bus.FCR_trig = 2'($urandom);
            if ($urandom_range(0, 999) < 5) begin
                bus.fifo_clear = 1'b1;
            end else if (q.size() < 16 && $urandom_range(0, 99) < 35) begin
                pdata             = 8'($urandom);
                bus.push_rx_fifo  = 1'b1;
                bus.parity_error  = ($urandom_range(0, 9) == 0);
                bus.framing_error = ($urandom_range(0, 9) == 0);
                bus.break_error   = ($urandom_range(0, 19) == 0);
                bus.rx_overrun    = ($urandom_range(0, 29) == 0);
            end
            if ($urandom_range(0, 99) < 25) bus.rbr_rd = 1'b1;
            if ($urandom_range(0, 99) < 10) bus.lsr_rd = 1'b1;
            cycle();
        end

        // Long idle stretch with a mid-count LCR change
        drain();
        bus.LCR = 8'h0F;
        push(8'h77, 0, 0, 0, 0);
        bus.enable = 1'b1;
        for (int i = 0; i < 900; i++) begin
            if (i == 300) bus.LCR = 8'h00;
            cycle();
        end
        pop();

        // Reset wins over a coincident push
        push(8'h10, 1, 0, 0, 0);
        push(8'h20, 0, 0, 0, 1);
        rst = 1'b1;
        push(8'h30, 0, 1, 0, 1);
        chk("prst_lsr", 16'(bus.lsr), 16'h00);
        chk("prst_irqs", 16'({bus.rx_data_irq, bus.rx_line_irq, bus.rx_timeout_irq}), 16'h0);
        rst = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_status.md
# uart_rx_status

Receive-side status and interrupt stage of the UART, sitting directly downstream of the RX engine and its 16-entry RX FIFO.
- Pops characters on host RBR reads and presents the head character masked to the configured word length.
- Keeps the 16550-style receive bits of the line status register (LSR), including sticky error flags and FIFO-error tracking.
- Raises the received-data, line-status and character-timeout interrupt requests.

## Interface
Parameters: none (FIFO depth fixed at 16).
- PCLK  in  1  system clock
- PRESET  in  1  synchronous, active-high reset
- enable  in  1  16x baud tick, same strobe the RX engine uses
- LCR  in  8  line control; uses [1:0] word length (5+n), [2] stop bits (0=1, 1=2), [3] parity enable
- FCR_trig  in  2  RX trigger level: 00=1, 01=4, 10=8, 11=14 characters
- fifo_clear  in  1  single-cycle pulse clearing the RX FIFO; this block clears its FIFO-related state
- rx_fifo_out  in  11  FIFO head: [7:0] data, [8] framing, [9] parity, [10] break
- rx_fifo_count  in  5  FIFO occupancy, 0..16
- rx_fifo_empty, rx_fifo_full  in  1  FIFO flags
- push_rx_fifo  in  1  one-cycle push strobe from the RX engine
- rx_overrun, parity_error, framing_error, break_error  in  1  RX engine flags, valid for the character being pushed while push_rx_fifo=1
- rbr_rd  in  1  host read of RBR
- lsr_rd  in  1  host read of LSR
- pop_rx_fifo  out  1  FIFO pop
- rbr  out  8  received character
- lsr  out  8  receive LSR bits; [6:5] driven 0 (transmit side owns them)
- rx_data_irq, rx_line_irq, rx_timeout_irq  out  1  interrupt requests

## Operation
Combinational paths:
- pop_rx_fifo = rbr_rd & ~rx_fifo_empty. An RBR read on an empty FIFO has no effect.
- rbr = rx_fifo_out[7:0], with bits at and above the word length forced to 0. It reads 0 when the FIFO is empty.

LSR bits:
- lsr[0] (DR) = ~rx_fifo_empty.
- lsr[1] (OE) is sticky. It sets when push_rx_fifo & rx_overrun.
- lsr[2] (PE), lsr[3] (FE) and lsr[4] (BI) are sticky:
  - Internal head_seen flag: cleared on pop_rx_fifo or fifo_clear.
  - While ~rx_fifo_empty & ~head_seen, OR rx_fifo_out[9], [8] and [10] into PE, FE and BI respectively, then set head_seen.
- lsr_rd clears OE, PE, FE and BI. A set in the same cycle wins over the clear.
- lsr[7] (FIFO error) = (err_cnt != 0). err_cnt is a 5-bit count of FIFO entries carrying an error:
  - +1 on push_rx_fifo & ~rx_fifo_full & (parity_error|framing_error|break_error).
  - −1 on pop_rx_fifo & |rx_fifo_out[10:8].
  - Simultaneous increment and decrement leave it unchanged.
  - It saturates at 0 and 16. fifo_clear zeroes it.

Interrupts:
- rx_data_irq is set while rx_fifo_count ≥ trigger level, else cleared.
- rx_line_irq = |lsr[4:1].
- rx_timeout_irq uses a 10-bit tick counter, to_cnt:
  - to_cnt is zeroed when rx_fifo_empty, push_rx_fifo, pop_rx_fifo or fifo_clear is true. Otherwise it increments on each enable and saturates.
  - frame_bits = 1 + (5+LCR[1:0]) + LCR[3] + 1 + LCR[2], giving a range of 7..12.
  - rx_timeout_irq sets when to_cnt ≥ 64×frame_bits (four character times) and the FIFO is non-empty.
  - It clears on pop_rx_fifo, fifo_clear, or the FIFO going empty.

## Timing
Reset values (PRESET synchronous, active-high, held ≥1 cycle):
- lsr = 8'h00, apart from DR, which follows rx_fifo_empty.
- rx_data_irq = 0, rx_line_irq = 0, rx_timeout_irq = 0.
- err_cnt = 0, to_cnt = 0, head_seen = 0.
- PRESET overrides all pending events, including a push arriving in the same cycle.

Latency:
- pop_rx_fifo, rbr, lsr[0] and lsr[7]: 0 cycles (combinational).
- Sticky LSR bits, rx_data_irq and rx_timeout_irq: registered, visible one cycle after the causing event.
- rx_line_irq is combinational from the registered LSR bits, so it also follows its cause by one cycle.

Host reads:
- The host samples lsr in the same cycle as lsr_rd. The clear takes effect on the next edge.
- A new head character exposed by a pop is evaluated one cycle later, when head_seen is low again.

Edge cases:
- A push into a full FIFO does not change err_cnt, but does set OE if rx_overrun=1.
- LCR changes mid-count take effect immediately against the current to_cnt.

## Configuration
- UART_RX_TIMEOUT_EN defined: to_cnt and rx_timeout_irq are implemented as described.
- UART_RX_TIMEOUT_EN undefined: no counter is built and rx_timeout_irq is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset, then push 3 error-free characters with FCR_trig=01 → rx_data_irq stays 0. The 4th push sets rx_data_irq=1 one cycle later. rbr_rd pops back to count 3 → rx_data_irq=0.
- LCR=8'h00 (5 bits), head data 8'hFF → rbr=8'h1F. LCR=8'h03 → rbr=8'hFF.
- Push A (framing_error=1), then B (clean), then C (parity_error=1):
  - lsr[3]=1, lsr[7]=1, err_cnt=2.
  - lsr_rd clears FE. Pop A → lsr[7] stays 1.
  - Pop B → C reaches the head → PE=1 next cycle. Pop C → lsr[7]=0.
- LCR=8'h03, one character in the FIFO, no activity → rx_timeout_irq rises after 640 enable ticks. rbr_rd clears it. With UART_RX_TIMEOUT_EN undefined it stays 0.
- FIFO full (count 16), push with rx_overrun=1 → lsr[1]=1, rx_line_irq=1, err_cnt unchanged. lsr_rd coinciding with a second overrun push → OE stays 1.
- Mid-stream fifo_clear with err_cnt=3 → err_cnt=0, lsr[7]=0, to_cnt=0. PRESET asserted together with a push → all outputs at reset values.
